// File: rtl/uio_bus_scheduler_if.sv
// Bundle of the requester handshake and the uio pad bus shared by the scheduler
// and the surrounding user logic / pad ring.
interface uio_bus_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
);
  logic                 ena;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   wr;
  logic [8*NUM_REQ-1:0] wdata;
  logic [7:0]           uio_in;
  logic [7:0]           uio_out;
  logic [7:0]           uio_oe;
  logic [NUM_REQ-1:0]   gnt;
  logic                 done;
  logic [IDW-1:0]       done_id;
  logic [7:0]           rdata;

  // User logic and pad side.
  modport master (
    output ena, req, wr, wdata, uio_in,
    input  uio_out, uio_oe, gnt, done, done_id, rdata
  );

  // Scheduler side.
  modport slave (
    input  ena, req, wr, wdata, uio_in,
    output uio_out, uio_oe, gnt, done, done_id, rdata
  );
endinterface

// File: rtl/uio_bus_scheduler.sv
// Round-robin scheduler time-sharing the 8-bit bidirectional uio pad bus between
// NUM_REQ requesters. Inserts one turnaround cycle on every direction change and
// returns read data with a done pulse. All outputs come straight from flops.
module uio_bus_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned HOLD    = 2,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input logic                 clk,
  input logic                 rst_n,
  uio_bus_scheduler_if.slave  bus
);

  localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {StIdle, StTurn, StXfer, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [7:0]         byte_q, byte_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               dir_q, dir_d;
  logic [CntW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               done_q, done_d;
  logic [IDW-1:0]     done_id_q, done_id_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [7:0]         uio_out_q, uio_out_d;
  logic [7:0]         uio_oe_q, uio_oe_d;

  logic               found;
  logic [IDW-1:0]     win;

  // Round-robin pick: first set req bit scanning upward from rr_ptr+1, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      logic [IDW-1:0] cand;
      cand = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state logic; registered outputs are derived from the next state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    byte_d     = byte_q;
    rr_ptr_d   = rr_ptr_q;
    dir_d      = dir_q;
    hold_cnt_d = hold_cnt_q;
    rdata_d    = rdata_q;
    done_id_d  = done_id_q;

    unique case (state_q)
      StIdle: begin
        hold_cnt_d = '0;
        if (bus.ena && found) begin
          idx_d    = win;
          wr_d     = bus.wr[win];
          byte_d   = bus.wdata[win*8 +: 8];
          rr_ptr_d = win;
          state_d  = (bus.wr[win] != dir_q) ? StTurn : StXfer;
        end
      end
      StTurn: begin
        dir_d   = wr_q;
        state_d = StXfer;
      end
      StXfer: begin
        if (hold_cnt_q == CntW'(HOLD - 1)) begin
          state_d = StDone;
          if (!wr_q) rdata_d = bus.uio_in;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    gnt_d     = (state_d != StIdle) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_d) : '0;
    done_d    = (state_d == StDone);
    if (state_d == StDone) done_id_d = idx_d;
    uio_oe_d  = (state_d == StXfer && wr_d) ? 8'hFF : 8'h00;
    uio_out_d = (state_d == StXfer && wr_d) ? byte_d : 8'h00;
  end

  // State and output registers; reset forces the pads to input immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      byte_q     <= 8'h00;
      rr_ptr_q   <= IDW'(NUM_REQ - 1);
      dir_q      <= 1'b0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
      rdata_q    <= 8'h00;
      uio_out_q  <= 8'h00;
      uio_oe_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      byte_q     <= byte_d;
      rr_ptr_q   <= rr_ptr_d;
      dir_q      <= dir_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      rdata_q    <= rdata_d;
      uio_out_q  <= uio_out_d;
      uio_oe_q   <= uio_oe_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.rdata   = rdata_q;
  assign bus.uio_out = uio_out_q;
  assign bus.uio_oe  = uio_oe_q;

endmodule

// File: tb/tb_uio_bus_scheduler.sv
// Bench for uio_bus_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_uio_bus_scheduler;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned HOLD    = 2;
  localparam int unsigned IDW     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uio_bus_scheduler_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

  uio_bus_scheduler #(.NUM_REQ(NUM_REQ), .HOLD(HOLD), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected outputs for one future cycle.
  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic [7:0]         oe;
    logic [7:0]         out;
    logic               done;
    logic [IDW-1:0]     id;
    logic               cap;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         rr;
  logic       dir;
  logic [7:0] exp_rdata;
  bit         cur_idle;
  bit         cap_pending;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    rr          = NUM_REQ - 1;
    dir         = 1'b0;
    exp_rdata   = 8'h00;
    cur_idle    = 1'b1;
    cap_pending = 1'b0;
  endtask

  // Transaction-level prediction using inputs of the current cycle.
  task automatic model_step();
    exp_t e;
    int   win;
    logic w;
    logic [7:0] b;
    if (cap_pending) begin
      exp_rdata   = bus.uio_in;
      cap_pending = 1'b0;
    end
    if (cur_idle && bus.ena && bus.req != '0) begin
      win = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int i;
        i = (rr + k) % NUM_REQ;
        if (win < 0 && bus.req[i]) win = i;
      end
      w = bus.wr[win];
      b = bus.wdata[win*8 +: 8];
      e.gnt = '0;
      e.gnt[win] = 1'b1;
      e.done = 1'b0;
      e.id = '0;
      e.cap = 1'b0;
      if (w != dir) begin
        e.oe = 8'h00;
        e.out = 8'h00;
        exp_q.push_back(e);
      end
      dir = w;
      for (int h = 0; h < HOLD; h++) begin
        e.oe  = w ? 8'hFF : 8'h00;
        e.out = w ? b : 8'h00;
        e.cap = !w && (h == HOLD - 1);
        exp_q.push_back(e);
      end
      e.oe = 8'h00;
      e.out = 8'h00;
      e.cap = 1'b0;
      e.done = 1'b1;
      e.id = IDW'(win);
      exp_q.push_back(e);
      rr = win;
    end
  endtask

  task automatic compare();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cur_idle = 1'b0;
    end else begin
      e.gnt = '0; e.oe = 8'h00; e.out = 8'h00; e.done = 1'b0; e.id = '0; e.cap = 1'b0;
      cur_idle = 1'b1;
    end
    chk("model_gnt", 32'(bus.gnt), 32'(e.gnt));
    chk("model_oe", 32'(bus.uio_oe), 32'(e.oe));
    chk("model_out", 32'(bus.uio_out), 32'(e.out));
    chk("model_done", 32'(bus.done), 32'(e.done));
    if (e.done) chk("model_done_id", 32'(bus.done_id), 32'(e.id));
    chk("model_rdata", 32'(bus.rdata), 32'(exp_rdata));
    if (e.cap) cap_pending = 1'b1;
  endtask

  // One clock cycle: predict from current inputs, clock, check.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic wait_done(input int max, output int id);
    bit seen;
    seen = 1'b0;
    id = -1;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (bus.done) begin
        seen = 1'b1;
        id = int'(bus.done_id);
      end
    end
    if (!seen) chk("done_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int id;
    int rot_exp[5];
    rot_exp = '{2, 3, 0, 1, 2};
    bus.ena = 1'b1; bus.req = '0; bus.wr = '0; bus.wdata = '0; bus.uio_in = 8'h00;
    model_reset();
    #12;
    chk("rst_oe", 32'(bus.uio_oe), 32'h00);
    chk("rst_out", 32'(bus.uio_out), 32'h00);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_rdata", 32'(bus.rdata), 32'h00);
    chk("rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read from requester 2, no turnaround.
    bus.req = 4'b0100; bus.uio_in = 8'hA5;
    tick();
    chk("rd_c1_gnt", 32'(bus.gnt), 32'h4);
    chk("rd_c1_oe", 32'(bus.uio_oe), 32'h00);
    tick();
    chk("rd_c2_gnt", 32'(bus.gnt), 32'h4);
    tick();
    chk("rd_c3_done", 32'(bus.done), 32'h1);
    chk("rd_c3_id", 32'(bus.done_id), 32'h2);
    chk("rd_c3_rdata", 32'(bus.rdata), 32'hA5);
    chk("rd_c3_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0; bus.uio_in = 8'h00;
    tick();

    // Write from requester 1 after a read: one turnaround cycle.
    bus.req = 4'b0010; bus.wr = 4'b0010; bus.wdata[15:8] = 8'h3C;
    tick();
    chk("wr_turn_oe", 32'(bus.uio_oe), 32'h00);
    chk("wr_turn_gnt", 32'(bus.gnt), 32'h2);
    tick();
    chk("wr_x1_oe", 32'(bus.uio_oe), 32'hFF);
    chk("wr_x1_out", 32'(bus.uio_out), 32'h3C);
    bus.wdata[15:8] = 8'h99;  // late change must not reach the pads
    tick();
    chk("wr_x2_out", 32'(bus.uio_out), 32'h3C);
    tick();
    chk("wr_done", 32'(bus.done), 32'h1);
    chk("wr_done_id", 32'(bus.done_id), 32'h1);
    bus.req = '0; bus.wr = '0;
    tick();

    // All requesters reading continuously: strict rotation after last winner 1.
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(10, id);
      chk("rot_id", 32'(id), 32'(rot_exp[n]));
    end
    bus.req = '0;
    tick();

    // ena low blocks grants; drop mid-transfer does not abort.
    bus.ena = 1'b0; bus.req = 4'b0001;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("ena_low_gnt", 32'(bus.gnt), 32'h0);
    end
    bus.ena = 1'b1;
    tick();
    chk("ena_gnt", 32'(bus.gnt), 32'h1);
    bus.ena = 1'b0;
    wait_done(10, id);
    chk("ena_drop_id", 32'(id), 32'h0);
    bus.req = '0; bus.ena = 1'b1;
    tick();

    // Write then write (no turnaround), then a read (one turnaround).
    bus.req = 4'b0100; bus.wr = 4'b0100; bus.wdata[23:16] = 8'h11;
    wait_done(10, id);
    bus.req = '0;
    tick();
    bus.req = 4'b0001; bus.wr = 4'b0001; bus.wdata[7:0] = 8'h22;
    tick();
    chk("ww_oe", 32'(bus.uio_oe), 32'hFF);
    chk("ww_out", 32'(bus.uio_out), 32'h22);
    wait_done(10, id);
    bus.req = '0;
    tick();
    bus.req = 4'b0010; bus.wr = 4'b0000; bus.uio_in = 8'h6B;
    tick();
    chk("wr_rd_turn_oe", 32'(bus.uio_oe), 32'h00);
    wait_done(10, id);
    chk("wr_rd_rdata", 32'(bus.rdata), 32'h6B);
    bus.req = '0;
    tick();

    // Reset during a write transfer.
    bus.req = 4'b1000; bus.wr = 4'b1000; bus.wdata[31:24] = 8'h5A;
    tick();
    tick();
    chk("pre_rst_oe", 32'(bus.uio_oe), 32'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_oe", 32'(bus.uio_oe), 32'h00);
    chk("async_rst_gnt", 32'(bus.gnt), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1001; bus.wr = '0;
    wait_done(10, id);
    chk("post_rst_id", 32'(id), 32'h0);
    bus.req = '0;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.ena    = ($urandom_range(0, 9) != 0);
      bus.req    = NUM_REQ'($urandom);
      bus.wr     = NUM_REQ'($urandom);
      bus.wdata  = 32'($urandom);
      bus.uio_in = 8'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
